// File: rtl/pf_pkg.sv
// Shared types and constants for the playfield pixel stage.
package pf_pkg;

    localparam int PIX_W  = 4;
    localparam int PAL_W  = 3;
    localparam int CODE_W = 12;
    localparam int ROW_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic             hflip;
        logic [PAL_W-1:0] pal;
        logic [CODE_W-1:0] code;
    } pf_word_t;

    // Put pixel 0 of the displayed order into the top nibble so the shifter
    // always emits from the MSB end; a flipped tile reverses the nibble order.
    function automatic logic [8*PIX_W-1:0] orient_row(
        input logic [8*PIX_W-1:0] row,
        input logic               flip
    );
        logic [8*PIX_W-1:0] r;
        r = row;
        if (flip) begin
            for (int i = 0; i < 8; i++) begin
                r[i*PIX_W +: PIX_W] = row[(7-i)*PIX_W +: PIX_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pf_fine_delay.sv
// Fine horizontal scroll: 8-position pixel/palette delay line with tap select.
// Tap 0 passes the shifter pixel straight into the output register.
module pf_fine_delay
    import pf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  logic [2:0]       tap,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [PAL_W-1:0] pal_in,
    output logic [PIX_W-1:0] pix_out,
    output logic [PAL_W-1:0] pal_out
);

    logic [PIX_W-1:0] pix_d [0:6];
    logic [PAL_W-1:0] pal_d [0:6];
    logic [PIX_W-1:0] pix_tap [0:7];
    logic [PAL_W-1:0] pal_tap [0:7];

    // Tap list: position 0 is the live input, position k is k strobes old.
    always_comb begin
        pix_tap[0] = pix_in;
        pal_tap[0] = pal_in;
        for (int k = 1; k < 8; k++) begin
            pix_tap[k] = pix_d[k-1];
            pal_tap[k] = pal_d[k-1];
        end
    end

    // Delay chain and output register; line start refills with transparent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 7; k++) begin
                pix_d[k] <= '0;
                pal_d[k] <= '0;
            end
            pix_out <= '0;
            pal_out <= '0;
        end else if (clr) begin
            for (int k = 0; k < 7; k++) begin
                pix_d[k] <= '0;
                pal_d[k] <= '0;
            end
            pix_out <= '0;
            pal_out <= '0;
        end else if (adv) begin
            pix_d[0] <= pix_in;
            pal_d[0] <= pal_in;
            for (int k = 1; k < 7; k++) begin
                pix_d[k] <= pix_d[k-1];
                pal_d[k] <= pal_d[k-1];
            end
            pix_out <= pix_tap[tap];
            pal_out <= pal_tap[tap];
        end
    end

endmodule

// File: rtl/pf_pixel_shifter.sv
// Playfield pixel stage: tile word capture, graphics-ROM row fetch,
// pixel serialisation with H-flip, and fine horizontal scroll.
module pf_pixel_shifter
    import pf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               line_start,
    input  logic               tile_ld,
    input  logic [15:0]        VRD_in,
    input  logic [8:0]         PP,
    input  logic               PP18,
    input  logic               PFHFLIP,
    input  logic [2:0]         hscroll_fine,
    output logic               gfx_req,
    output logic [15:0]        gfx_addr,
    input  logic               gfx_ack,
    input  logic [8*PIX_W-1:0] gfx_data,
    output logic [PIX_W-1:0]   PF_PIX,
    output logic [PAL_W-1:0]   PF_PAL,
    output logic               PF_OPAQUE,
    output logic               underrun,
    output logic               overrun
);

    fetch_state_t       state;
    pf_word_t           tile_w;
    logic [PAL_W-1:0]   hold_pal;
    logic               hold_flip;
    logic [8*PIX_W-1:0] hold_row;
    logic [2:0]         px_cnt;
    logic [8*PIX_W-1:0] sh_row;
    logic [PAL_W-1:0]   sh_pal;
    logic [2:0]         tap_q;
    logic               boundary;
    logic               unused_pp;

    assign tile_w    = VRD_in;
    assign unused_pp = ^PP[8:ROW_W];

    // Line start takes precedence, so a coincident strobe never loads a row.
    assign boundary  = pix_en && !line_start && (px_cnt == 3'd7);

    // Fetch FSM: one tile in flight; extra tile words while busy are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gfx_req   <= 1'b0;
            gfx_addr  <= '0;
            hold_pal  <= '0;
            hold_flip <= 1'b0;
            hold_row  <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tile_ld) begin
                        state     <= REQ;
                        gfx_req   <= 1'b1;
                        gfx_addr  <= {PP18, tile_w.code, PP[ROW_W-1:0]};
                        hold_pal  <= tile_w.pal;
                        hold_flip <= tile_w.hflip ^ PFHFLIP;
                    end
                end
                REQ: begin
                    if (gfx_ack) begin
                        state    <= FULL;
                        gfx_req  <= 1'b0;
                        hold_row <= gfx_data;
                    end
                end
                FULL: begin
                    if (boundary) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (tile_ld && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Pixel counter and shifter; a missing row at the boundary shows as transparent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_cnt   <= '0;
            sh_row   <= '0;
            sh_pal   <= '0;
            tap_q    <= '0;
            underrun <= 1'b0;
        end else if (line_start) begin
            px_cnt <= '0;
            sh_row <= '0;
            sh_pal <= '0;
            tap_q  <= hscroll_fine;
        end else if (pix_en) begin
            px_cnt <= px_cnt + 3'd1;
            if (boundary) begin
                if (state == FULL) begin
                    sh_row <= orient_row(hold_row, hold_flip);
                    sh_pal <= hold_pal;
                end else begin
                    sh_row   <= '0;
                    sh_pal   <= '0;
                    underrun <= 1'b1;
                end
            end else begin
                sh_row <= sh_row << PIX_W;
            end
        end
    end

    pf_fine_delay u_fine_delay (
        .clk     (clk),
        .rst     (rst),
        .adv     (pix_en),
        .clr     (line_start),
        .tap     (tap_q),
        .pix_in  (sh_row[8*PIX_W-1 -: PIX_W]),
        .pal_in  (sh_pal),
        .pix_out (PF_PIX),
        .pal_out (PF_PAL)
    );

    assign PF_OPAQUE = |PF_PIX;

endmodule

// File: tb/tb_pf_pixel_shifter.sv
// Directed bench for pf_pixel_shifter with an expected-pixel scoreboard.
module tb_pf_pixel_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        line_start;
    logic        tile_ld;
    logic [15:0] VRD_in;
    logic [8:0]  PP;
    logic        PP18;
    logic        PFHFLIP;
    logic [2:0]  hscroll_fine;
    logic        gfx_req;
    logic [15:0] gfx_addr;
    logic        gfx_ack;
    logic [31:0] gfx_data;
    logic [3:0]  PF_PIX;
    logic [2:0]  PF_PAL;
    logic        PF_OPAQUE;
    logic        underrun;
    logic        overrun;

    typedef struct packed {
        logic [3:0] pix;
        logic [2:0] pal;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pf_pixel_shifter dut (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .line_start   (line_start),
        .tile_ld      (tile_ld),
        .VRD_in       (VRD_in),
        .PP           (PP),
        .PP18         (PP18),
        .PFHFLIP      (PFHFLIP),
        .hscroll_fine (hscroll_fine),
        .gfx_req      (gfx_req),
        .gfx_addr     (gfx_addr),
        .gfx_ack      (gfx_ack),
        .gfx_data     (gfx_data),
        .PF_PIX       (PF_PIX),
        .PF_PAL       (PF_PAL),
        .PF_OPAQUE    (PF_OPAQUE),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel strobe (optionally with a ROM ack), then compare against the scoreboard.
    task automatic strobe(input logic ack);
        exp_t e;
        @(negedge clk);
        pix_en  = 1'b1;
        gfx_ack = ack;
        @(negedge clk);
        pix_en  = 1'b0;
        gfx_ack = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pf_pix", {28'd0, PF_PIX}, {28'd0, e.pix});
            chk("pf_pal", {29'd0, PF_PAL}, {29'd0, e.pal});
            chk("pf_opaque", {31'd0, PF_OPAQUE}, {31'd0, (e.pix != 4'd0)});
        end
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) strobe(1'b0);
    endtask

    task automatic push_zeros(input int n);
        exp_t e;
        e.pix = 4'd0;
        e.pal = 3'd0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Expected displayed order of a ROM row: pixel 0 is [31:28] unless flipped.
    task automatic push_row(input logic [31:0] data, input logic flip, input logic [2:0] pal);
        exp_t e;
        logic [31:0] d;
        d = data;
        for (int i = 0; i < 8; i++) begin
            e.pix = flip ? d[4*i +: 4] : d[28-4*i +: 4];
            e.pal = pal;
            sb.push_back(e);
        end
    endtask

    task automatic do_line_start(input logic [2:0] hs);
        @(negedge clk);
        line_start   = 1'b1;
        hscroll_fine = hs;
        @(negedge clk);
        line_start   = 1'b0;
        chk("line_start_pix", {28'd0, PF_PIX}, 32'd0);
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (gfx_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("gfx_req_rise", {31'd0, gfx_req}, 32'd1);
    endtask

    task automatic fetch(input logic [15:0] vrd, input logic pfh);
        @(negedge clk);
        tile_ld = 1'b1;
        VRD_in  = vrd;
        PFHFLIP = pfh;
        @(negedge clk);
        tile_ld = 1'b0;
        wait_req();
    endtask

    task automatic ack(input logic [31:0] data);
        @(negedge clk);
        gfx_ack  = 1'b1;
        gfx_data = data;
        @(negedge clk);
        gfx_ack  = 1'b0;
        chk("gfx_req_drop", {31'd0, gfx_req}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        pix_en       = 1'b0;
        line_start   = 1'b0;
        tile_ld      = 1'b0;
        VRD_in       = '0;
        PP           = '0;
        PP18         = 1'b0;
        PFHFLIP      = 1'b0;
        hscroll_fine = '0;
        gfx_ack      = 1'b0;
        gfx_data     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pix", {28'd0, PF_PIX}, 32'd0);
        chk("rst_pal", {29'd0, PF_PAL}, 32'd0);
        chk("rst_opaque", {31'd0, PF_OPAQUE}, 32'd0);
        chk("rst_req", {31'd0, gfx_req}, 32'd0);
        chk("rst_addr", {16'd0, gfx_addr}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;

        // No tile: transparent output, underrun at the first boundary
        push_zeros(8);
        strobes(7);
        chk("underrun_pre", {31'd0, underrun}, 32'd0);
        strobes(1);
        chk("underrun_empty", {31'd0, underrun}, 32'd1);

        // Normal tile fetch and serialisation
        PP   = 9'h005;
        PP18 = 1'b1;
        do_line_start(3'd0);
        fetch(16'h2ABC, 1'b0);
        chk("gfx_addr", {16'd0, gfx_addr}, 32'h0000D5E5);
        ack(32'h12345678);
        push_zeros(8);
        push_row(32'h12345678, 1'b0, 3'd2);
        strobes(16);
        chk("overrun_clean", {31'd0, overrun}, 32'd0);

        // Tile H-flip, then tile flip cancelled by screen flip
        do_line_start(3'd0);
        fetch(16'hAABC, 1'b0);
        ack(32'h12345678);
        push_zeros(8);
        push_row(32'h12345678, 1'b1, 3'd2);
        strobes(16);

        do_line_start(3'd0);
        fetch(16'hAABC, 1'b1);
        ack(32'h12345678);
        push_zeros(8);
        push_row(32'h12345678, 1'b0, 3'd2);
        strobes(16);

        // Fine scroll of 3 pixels
        do_line_start(3'd3);
        hscroll_fine = 3'd0;
        PFHFLIP      = 1'b0;
        fetch(16'h2ABC, 1'b0);
        ack(32'h12345678);
        push_zeros(11);
        push_row(32'h12345678, 1'b0, 3'd2);
        strobes(19);

        // Reset while a request is outstanding
        do_line_start(3'd0);
        fetch(16'h2ABC, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_req", {31'd0, gfx_req}, 32'd0);
        chk("async_underrun", {31'd0, underrun}, 32'd0);
        chk("async_addr", {16'd0, gfx_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        PP   = 9'h1FA;
        PP18 = 1'b0;
        do_line_start(3'd0);
        fetch(16'h5123, 1'b0);
        chk("gfx_addr2", {16'd0, gfx_addr}, 32'h0000091A);
        ack(32'h9ABC0DEF);
        push_zeros(8);
        push_row(32'h9ABC0DEF, 1'b0, 3'd5);
        strobes(15);
        chk("underrun_ok", {31'd0, underrun}, 32'd0);
        strobes(1);
        chk("underrun_idle", {31'd0, underrun}, 32'd1);

        // Clear stickies, then overrun and late ack coinciding with the boundary
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst2_underrun", {31'd0, underrun}, 32'd0);
        PP   = 9'h005;
        PP18 = 1'b1;
        do_line_start(3'd0);
        fetch(16'h2ABC, 1'b0);
        @(negedge clk);
        tile_ld = 1'b1;
        VRD_in  = 16'h1111;
        PP18    = 1'b0;
        @(negedge clk);
        tile_ld = 1'b0;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("addr_kept", {16'd0, gfx_addr}, 32'h0000D5E5);
        gfx_data = 32'h12345678;
        push_zeros(8);
        strobes(7);
        chk("underrun_late_pre", {31'd0, underrun}, 32'd0);
        strobe(1'b1);
        chk("underrun_late", {31'd0, underrun}, 32'd1);
        chk("late_req_drop", {31'd0, gfx_req}, 32'd0);
        push_zeros(8);
        push_row(32'h12345678, 1'b0, 3'd2);
        strobes(16);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
